// File: rtl/seq_divider.sv
// Unsigned sequential divider, restoring shift-subtract, one quotient bit per clock.
// Latency: done pulses N+1 cycles after the accept edge (1 cycle for a zero divisor).
// Backpressure: none; start is only honoured in IDLE and ignored while busy.
module seq_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Iteration counter, 0..N-1 across the CALC phase.
  logic [CW-1:0] cnt;

  // Shared dividend/quotient register: dividend bits leave at the MSB while
  // quotient bits enter at the LSB, so after N steps it holds the quotient.
  logic [N-1:0] dq_sh;

  // Latched divisor and the stored partial remainder. The stored value is
  // always strictly below the divisor, so N bits suffice between steps.
  logic [N-1:0] dsr;
  logic [N-1:0] rem;

  // (N+1)-bit working remainder after shifting in the next dividend bit.
  logic [N:0]   rem_shift;
  logic         q_bit;
  logic [N-1:0] rem_next;
  logic         last_step;

  // One restoring step: shift, trial-subtract, keep the difference if non-negative.
  always_comb begin
    rem_shift = {rem, dq_sh[N-1]};
    q_bit     = (rem_shift >= {1'b0, dsr});
    rem_next  = rem_shift[N-1:0];
    if (q_bit) begin
      rem_next = N'(rem_shift - {1'b0, dsr});
    end
    last_step = (cnt == CW'(N - 1));
  end

  // Control FSM with registered outputs; async reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dq_sh       <= '0;
      dsr         <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dq_sh       <= dividend;
            dsr         <= divisor;
            rem         <= '0;
            cnt         <= '0;
            busy        <= 1'b1;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              // Zero divisor short-circuits straight to the result phase.
              quotient  <= '1;
              remainder <= dividend;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          rem   <= rem_next;
          dq_sh <= {dq_sh[N-2:0], q_bit};
          cnt   <= cnt + CW'(1);
          if (last_step) begin
            // Publish the final step directly so results appear with done.
            quotient  <= {dq_sh[N-2:0], q_bit};
            remainder <= rem_next;
            done      <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end
        end

        DONE: begin
          // Single-cycle result phase; outputs keep their values in IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
